// File: rtl/branch_pred_if.sv
// Bundle of the lookup (ID), update (EX), statistics and status signals exchanged
// between the pipeline and the branch prediction counter table.
interface branch_pred_if;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic [1:0]  pred_state;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_state;
    logic        upd_mispredict;
    logic        clear_stats;
    logic        busy;
    logic [15:0] br_count;
    logic [15:0] miss_count;

    // Pipeline side: drives lookups and resolved updates, observes predictions.
    modport master (
        output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_state,
               upd_mispredict, clear_stats,
        input  pred_state, pred_taken, busy, br_count, miss_count
    );

    // Table side: answers lookups and absorbs updates.
    modport slave (
        input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_state,
               upd_mispredict, clear_stats,
        output pred_state, pred_taken, busy, br_count, miss_count
    );
endinterface

// File: rtl/branch_pred_table.sv
// Direct-mapped table of 2-bit branch prediction counters. After every reset a
// sweep writes INIT_STATE into every entry; afterwards the EX stage writes back
// resolved counter states, with a write-first bypass to the ID-stage lookup.
// Saturating counters track resolved branches and mispredicts.
module branch_pred_table #(
    parameter int         INDEX_W    = 4,
    parameter logic [1:0] INIT_STATE = 2'b11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    branch_pred_if.slave bus
);

    localparam int                 DEPTH    = 1 << INDEX_W;
    localparam logic [INDEX_W-1:0] PTR_LAST = '1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t             state_q, state_d;
    logic [INDEX_W-1:0] ptr_q, ptr_d;
    logic [15:0]        br_count_q, br_count_d;
    logic [15:0]        miss_count_q, miss_count_d;
    logic [1:0]         table_q [DEPTH];

    logic               wr_en;
    logic [INDEX_W-1:0] wr_idx;
    logic [1:0]         wr_data;
    logic [INDEX_W-1:0] upd_idx;
    logic [INDEX_W-1:0] lookup_idx;
    logic [1:0]         pred_state;
    logic               unused_pc_bits;

    // Word-aligned instructions: the low two PC bits never select an entry.
    assign upd_idx    = bus.upd_pc[INDEX_W+1:2];
    assign lookup_idx = bus.lookup_pc[INDEX_W+1:2];
    assign unused_pc_bits = ^{bus.upd_pc[31:INDEX_W+2], bus.upd_pc[1:0],
                              bus.lookup_pc[31:INDEX_W+2], bus.lookup_pc[1:0]};

    // Next-state logic: init sweep sequencing, table write selection and statistics.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        wr_en        = 1'b0;
        wr_idx       = upd_idx;
        wr_data      = bus.upd_state;
        case (state_q)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_idx  = ptr_q;
                wr_data = INIT_STATE;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                if (bus.upd_valid) begin
                    wr_en = 1'b1;
                    if (br_count_q != 16'hFFFF) begin
                        br_count_d = br_count_q + 16'd1;
                    end
                    if (bus.upd_mispredict && (miss_count_q != 16'hFFFF)) begin
                        miss_count_d = miss_count_q + 16'd1;
                    end
                end
                if (bus.clear_stats) begin
                    br_count_d   = 16'd0;
                    miss_count_d = 16'd0;
                end
            end
        endcase
    end

    // Control state and statistics registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            br_count_q   <= 16'd0;
            miss_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Counter storage has no reset; only the sweep or EX updates write it.
    always_ff @(posedge clk_i) begin
        if (rst_i && wr_en) begin
            table_q[wr_idx] <= wr_data;
        end
    end

    // Combinational prediction: fixed INIT_STATE while sweeping, else write-first read.
    always_comb begin
        pred_state = table_q[lookup_idx];
        if (state_q == ST_INIT) begin
            pred_state = INIT_STATE;
        end else if (bus.upd_valid && (upd_idx == lookup_idx)) begin
            pred_state = bus.upd_state;
        end
    end

    assign bus.pred_state = pred_state;
    assign bus.pred_taken = pred_state[1] & bus.lookup_valid;
    assign bus.busy       = (state_q == ST_INIT);
    assign bus.br_count   = br_count_q;
    assign bus.miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_pred_table.sv
// Directed self-checking bench for branch_pred_table (INDEX_W=4, INIT_STATE=2'b11).
module tb_branch_pred_table;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    branch_pred_if bus ();

    branch_pred_table #(.INDEX_W(4), .INIT_STATE(2'b11)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.lookup_valid   = 1'b0;
        bus.lookup_pc      = 32'h0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = 32'h0;
        bus.upd_state      = 2'b00;
        bus.upd_mispredict = 1'b0;
        bus.clear_stats    = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [1:0] st, input logic miss);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_state      = st;
        bus.upd_mispredict = miss;
        tick();
        bus.upd_valid      = 1'b0;
        bus.upd_mispredict = 1'b0;
    endtask

    task automatic check_lookup(input string name, input logic [31:0] pc, input logic vld,
                                input logic [1:0] exp_st, input logic exp_tk);
        bus.lookup_pc    = pc;
        bus.lookup_valid = vld;
        #1;
        n_checks++;
        if (bus.pred_state !== exp_st || bus.pred_taken !== exp_tk) begin
            n_fail++;
            $display("[TB] FAIL %s pc=%h: state=%b taken=%b, required state=%b taken=%b",
                     name, pc, bus.pred_state, bus.pred_taken, exp_st, exp_tk);
        end
    endtask

    task automatic check_counts(input string name, input logic [15:0] exp_br, input logic [15:0] exp_miss);
        n_checks++;
        if (bus.br_count !== exp_br || bus.miss_count !== exp_miss) begin
            n_fail++;
            $display("[TB] FAIL %s: br=%h miss=%h, required br=%h miss=%h",
                     name, bus.br_count, bus.miss_count, exp_br, exp_miss);
        end
    endtask

    // Counts 16 busy cycles after reset release, then expects busy to drop.
    task automatic run_sweep(input string name);
        int busy_errs;
        busy_errs = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.busy !== 1'b1) busy_errs++;
            tick();
        end
        n_checks++;
        if (busy_errs != 0) begin
            n_fail++;
            $display("[TB] FAIL %s_busy_high: %0d of 16 sweep cycles not busy, required 0", name, busy_errs);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s_busy_drop: busy=%b, required 0", name, bus.busy);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_busy: busy=%b, required 1", bus.busy);
        end
        check_counts("reset_counts", 16'h0000, 16'h0000);
        check_lookup("reset_pred", 32'h0000_0024, 1'b1, 2'b11, 1'b1);
        check_lookup("reset_pred_novalid", 32'h0000_0024, 1'b0, 2'b11, 1'b0);
    endtask

    task automatic test_init_sweep();
        rst_n = 1'b1;
        run_sweep("init");
        check_lookup("init_pc00", 32'h0000_0000, 1'b1, 2'b11, 1'b1);
        check_lookup("init_pc1c", 32'h0000_001C, 1'b1, 2'b11, 1'b1);
        check_lookup("init_pc3c", 32'h0000_003C, 1'b1, 2'b11, 1'b1);
        check_lookup("init_pc_novalid", 32'h0000_0028, 1'b0, 2'b11, 1'b0);
        check_counts("init_counts", 16'h0000, 16'h0000);
    endtask

    task automatic test_lookup_alias();
        do_update(32'h0000_0040, 2'b01, 1'b0);
        check_lookup("lookup_40", 32'h0000_0040, 1'b1, 2'b01, 1'b0);
        check_lookup("alias_80", 32'h0000_0080, 1'b1, 2'b01, 1'b0);
        check_lookup("neighbour_44", 32'h0000_0044, 1'b1, 2'b11, 1'b1);
        do_update(32'h0000_0008, 2'b10, 1'b0);
        check_lookup("taken_gate_off", 32'h0000_0008, 1'b0, 2'b10, 1'b0);
        check_lookup("taken_gate_on", 32'h0000_000B, 1'b1, 2'b10, 1'b1);
        check_counts("lookup_counts", 16'd2, 16'd0);
    endtask

    task automatic test_bypass();
        bus.upd_valid = 1'b1;
        bus.upd_pc    = 32'h0000_0010;
        bus.upd_state = 2'b00;
        check_lookup("bypass_same_cycle", 32'h0000_0010, 1'b1, 2'b00, 1'b0);
        check_lookup("bypass_other_idx", 32'h0000_0014, 1'b1, 2'b11, 1'b1);
        bus.lookup_pc = 32'h0000_0010;
        tick();
        bus.upd_valid = 1'b0;
        check_lookup("bypass_next_cycle", 32'h0000_0010, 1'b1, 2'b00, 1'b0);
    endtask

    task automatic test_stats();
        bus.clear_stats = 1'b1;
        tick();
        bus.clear_stats = 1'b0;
        check_counts("stats_cleared", 16'd0, 16'd0);
        do_update(32'h0000_0100, 2'b11, 1'b0);
        do_update(32'h0000_0104, 2'b10, 1'b1);
        do_update(32'h0000_0108, 2'b11, 1'b0);
        do_update(32'h0000_010C, 2'b01, 1'b1);
        do_update(32'h0000_0110, 2'b11, 1'b0);
        check_counts("stats_5_2", 16'd5, 16'd2);
        bus.clear_stats = 1'b1;
        do_update(32'h0000_0114, 2'b00, 1'b1);
        bus.clear_stats = 1'b0;
        check_counts("stats_clear_wins", 16'd0, 16'd0);
        do_update(32'h0000_0118, 2'b11, 1'b1);
        check_counts("stats_after_clear", 16'd1, 16'd1);
        force dut.br_count_q   = 16'hFFFF;
        force dut.miss_count_q = 16'hFFFF;
        #1;
        release dut.br_count_q;
        release dut.miss_count_q;
        do_update(32'h0000_011C, 2'b11, 1'b1);
        check_counts("stats_saturate", 16'hFFFF, 16'hFFFF);
    endtask

    task automatic test_reset_mid_sweep();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run_sweep("midreset");
        check_counts("midreset_counts", 16'd0, 16'd0);
    endtask

    task automatic test_update_during_init();
        do_update(32'h0000_0000, 2'b00, 1'b0);
        check_lookup("preinit_idx0", 32'h0000_0000, 1'b1, 2'b00, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = 32'h0000_0000;
        bus.upd_state      = 2'b00;
        bus.upd_mispredict = 1'b1;
        check_lookup("init_no_bypass", 32'h0000_0000, 1'b1, 2'b11, 1'b1);
        run_sweep("initupd");
        idle_inputs();
        check_lookup("initupd_idx0", 32'h0000_0000, 1'b1, 2'b11, 1'b1);
        check_counts("initupd_counts", 16'd0, 16'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_init_sweep();
        test_lookup_alias();
        test_bypass();
        test_stats();
        test_reset_mid_sweep();
        test_update_during_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
